ncl_mult3_sched: RTL and testbench
==================================

Name: ncl_mult3_sched

Overview:
- Synchronous scheduler that shares one NCL 3×3 dual-rail multiplier among N single-rail requesters.
- Arbitrates round-robin and encodes the winner's operands as a dual-rail DATA wavefront.
- Detects output completion, captures the 6-bit product, then drives the NULL wavefront and returns the multiplier to NULL before the next grant.
- Sits between the clocked request fabric and the asynchronous multiplier island; also owns the island's reset.

Parameters:
- N, 4, number of requesters (2..8).
- SYNC, 2, synchronizer flops on every asynchronous input (ko, p_rail*).
- TMO_CYC, 64, cycles allowed per wavefront phase before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request, level; held until gnt.
- req_a  in  3*N  operand A for requester i at bits [3i+2:3i].
- req_b  in  3*N  operand B for requester i at bits [3i+2:3i].
- gnt  out  N  one-hot, 1-cycle pulse when a request is accepted.
- rsp_valid  out  1  1-cycle pulse, result available.
- rsp_id  out  $clog2(N)  requester index for the result.
- rsp_p  out  6  product A*B.
- rsp_err  out  1  qualifies rsp_valid: timeout or illegal rail code.
- busy  out  1  high whenever state != IDLE.
- a_rail1, a_rail0  out  3  dual-rail A to multiplier.
- b_rail1, b_rail0  out  3  dual-rail B to multiplier.
- ki  out  1  acknowledge into multiplier output stage.
- mult_rst  out  1  reset to multiplier island.
- ko  in  1  multiplier acknowledge; 1 = ready for DATA, 0 = ready for NULL.
- p_rail1, p_rail0  in  6  dual-rail product from multiplier.

Behaviour:
- Reset (sync, active-high):
  - State → RST_ISL; all rail outputs 0 (NULL).
  - gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_p=0, busy=1, ki=1, mult_rst=1.
  - Round-robin pointer → 0; all synchronizer flops → 0.
- All async inputs pass through SYNC flops before use. Decisions use synchronized values only.
- Completion decode (synchronized):
  - dcomp = every bit has exactly one rail high.
  - ncomp = all 12 rails low.
  - illegal = any bit with both rails high.
- FSM states and transitions:
  - RST_ISL: mult_rst=1 for 4 cycles, then deassert and go to WAIT_N. This lets the island settle to NULL.
  - IDLE: busy=0. If any req, grant highest-priority requester at or after pointer (wrapping N-1→0).
    - gnt pulses for that cycle; latch operands and id; pointer ← winner+1 mod N.
    - Go to ISSUE.
  - ISSUE: wait for synchronized ko=1, then drive rails (rail1=bit, rail0=~bit, all 6 pairs in the same cycle). Go to WAIT_D.
  - WAIT_D: on dcomp, capture rsp_p (bit = p_rail1) and go to CLEAR.
    - illegal → ERR.
    - Counter reaching TMO_CYC → ERR.
  - CLEAR: drive all operand rails to 0 (NULL); ki=0 for exactly this phase. Go to WAIT_N.
  - WAIT_N: wait for ncomp and synchronized ko=1; then ki=1.
    - If a result is pending, go to RESP; otherwise (post-reset) go to IDLE.
    - Timeout → ERR.
  - RESP: rsp_valid=1 with rsp_err=0 for one cycle. Go to IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_p=0 for one cycle. Go to RST_ISL. The pending request is consumed, not retried.
- Phase counter clears on every state entry and saturates at TMO_CYC.
- ki is 1 except in CLEAR and WAIT_N before ncomp.
- Minimum grant-to-rsp_valid latency: 2*SYNC+5 cycles. No new gnt until RESP completes (one operation in flight).
- req dropped after gnt has no effect. req held after rsp is treated as a new request.
- Simultaneous req from all N: served strictly round-robin; each requester at most once per N operations.
- rst asserted in any state aborts the operation with no rsp_valid; outputs take reset values on the next edge.

Test Plan:
- Single requester 0, A=5, B=7; model multiplier returns dual-rail 35 → gnt[0] once; rails A=101/010, B=111/000; rsp_p=35, rsp_id=0, rsp_err=0; rails NULL before IDLE.
- All 4 req high continuously, pointer 0 → grant order 0,1,2,3,0; each rsp_id matches grant; no overlap of DATA wavefronts.
- Corner operands 0×0, 7×7, 7×1 → rsp_p 0, 49, 7; with SYNC=2, grant-to-rsp_valid latency ≥ 9 cycles.
- Model never reaches dcomp → after TMO_CYC cycles in WAIT_D: rsp_valid=1, rsp_err=1, rsp_p=0; mult_rst high 4 cycles; next request served normally.
- Model drives p bit 3 with both rails high → ERR response within SYNC+1 cycles; island reset sequence follows.
- rst pulsed during WAIT_D → no rsp_valid; the next cycle shows all rails 0, mult_rst=1, gnt=0, busy=1, ki=1.

Source files
------------

// File: rtl/ncl_mult3_sched.sv
// rtl/ncl_mult3_sched.sv - round-robin scheduler sharing one NCL 3x3 dual-rail multiplier
module ncl_mult3_sched #(
  parameter int N       = 4,
  parameter int SYNC    = 2,
  parameter int TMO_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [3*N-1:0]       req_a,
  input  logic [3*N-1:0]       req_b,
  output logic [N-1:0]         gnt,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [5:0]           rsp_p,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [2:0]           a_rail1,
  output logic [2:0]           a_rail0,
  output logic [2:0]           b_rail1,
  output logic [2:0]           b_rail0,
  output logic                 ki,
  output logic                 mult_rst,
  input  logic                 ko,
  input  logic [5:0]           p_rail1,
  input  logic [5:0]           p_rail0
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    RST_ISL, WAIT_N, IDLE, ISSUE, WAIT_D, CLEAR, RESP, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, win;
  logic [IW:0]   idx;
  logic          any_req;
  logic [2:0]    op_a, op_b;
  logic          pending;
  logic [12:0]   sync_q [SYNC];
  logic          ko_s;
  logic [5:0]    p1_s, p0_s;
  logic          dcomp, ncomp, illegal, tmo;

  // ko and both product rails share one synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {ko, p_rail1, p_rail0};
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {ko_s, p1_s, p0_s} = sync_q[SYNC-1];
  assign dcomp   = &(p1_s ^ p0_s);
  assign ncomp   = ~|(p1_s | p0_s);
  assign illegal = |(p1_s & p0_s);
  assign tmo     = (cnt == CW'(TMO_CYC));

  // first requester at or after ptr, wrapping
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      if (!any_req && req[idx[IW-1:0]]) begin
        any_req = 1'b1;
        win     = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST_ISL: if (cnt == CW'(3)) state_nxt = WAIT_N;
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (ko_s)     state_nxt = WAIT_D;
        else if (tmo) state_nxt = ERR;
      end
      WAIT_D: begin
        if (illegal)    state_nxt = ERR;
        else if (dcomp) state_nxt = CLEAR;
        else if (tmo)   state_nxt = ERR;
      end
      CLEAR:   state_nxt = WAIT_N;
      WAIT_N: begin
        if (ncomp && ko_s) state_nxt = pending ? RESP : IDLE;
        else if (tmo)      state_nxt = ERR;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = RST_ISL;
      default: state_nxt = RST_ISL;
    endcase
  end

  assign gnt       = (state == IDLE && any_req) ? (N'(1) << win) : '0;
  assign busy      = (state != IDLE);
  assign mult_rst  = (state == RST_ISL);
  assign rsp_valid = (state == RESP) || (state == ERR);
  assign rsp_err   = (state == ERR);
  assign ki        = !((state == CLEAR) || (state == WAIT_N && !ncomp));

  // rail changes are registered: the phase that decides them is followed by the wait phase that sees them
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_ISL;
      cnt     <= '0;
      ptr     <= '0;
      rsp_id  <= '0;
      rsp_p   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      pending <= 1'b0;
      a_rail1 <= '0;
      a_rail0 <= '0;
      b_rail1 <= '0;
      b_rail0 <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (!tmo)          cnt <= cnt + 1'b1;

      if (state == IDLE && any_req) begin
        ptr    <= (win == IW'(N-1)) ? '0 : win + 1'b1;
        rsp_id <= win;
        op_a   <= req_a[3*win +: 3];
        op_b   <= req_b[3*win +: 3];
      end

      if (state == ISSUE && ko_s) begin
        a_rail1 <= op_a;
        a_rail0 <= ~op_a;
        b_rail1 <= op_b;
        b_rail0 <= ~op_b;
      end

      if (state == CLEAR || state == ERR) begin
        a_rail1 <= '0;
        a_rail0 <= '0;
        b_rail1 <= '0;
        b_rail0 <= '0;
      end

      if (state == WAIT_D && state_nxt == CLEAR) begin
        rsp_p   <= p1_s;
        pending <= 1'b1;
      end
      if (state == RESP) pending <= 1'b0;
      if (state_nxt == ERR) begin
        rsp_p   <= '0;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ncl_mult3_sched.sv
// tb/tb_ncl_mult3_sched.sv - directed bench with a zero-delay dual-rail multiplier model
module tb_ncl_mult3_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'hF;
  logic [11:0] req_a = '0, req_b = '0;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_err, busy, ki, mult_rst, ko;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_p, p_rail1, p_rail0, prod;
  logic [2:0]  a_rail1, a_rail0, b_rail1, b_rail0;

  int mode = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  int ki_low, gnt_seen;
  logic [11:0] rails_d, rails_r;

  ncl_mult3_sched #(.N(4), .SYNC(2), .TMO_CYC(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_err(rsp_err), .busy(busy),
    .a_rail1(a_rail1), .a_rail0(a_rail0), .b_rail1(b_rail1), .b_rail0(b_rail0),
    .ki(ki), .mult_rst(mult_rst), .ko(ko), .p_rail1(p_rail1), .p_rail0(p_rail0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0 normal, 1 never completes, 2 bit 3 driven with both rails high
  always_comb begin
    prod    = {3'b000, a_rail1} * {3'b000, b_rail1};
    p_rail1 = '0;
    p_rail0 = '0;
    if (!mult_rst && mode != 1 && (&(a_rail1 ^ a_rail0)) && (&(b_rail1 ^ b_rail0))) begin
      p_rail1 = prod;
      p_rail0 = ~prod;
      if (mode == 2) begin
        p_rail1[3] = 1'b1;
        p_rail0[3] = 1'b1;
      end
    end
  end
  assign ko = ~|{p_rail1, p_rail0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    logic done;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 1);
    check("rst_mult_rst", 32'(mult_rst), 1);
    check("rst_ki", 32'(ki), 1);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_p}), 0);
    check("rst_rails", 32'({a_rail1, a_rail0, b_rail1, b_rail0}), 0);
    req  = '0;
    rst  = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = !busy;
    end
    check("rst_to_idle", 32'(done), 1);
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int t);
    logic found;
    found = 1'b0;
    g = '0;
    t = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      #1;
      if (gnt != 0) begin
        found = 1'b1;
        g = gnt;
        t = cyc;
        check("gnt_rails_null", 32'({a_rail1, a_rail0, b_rail1, b_rail0}), 0);
      end else begin
        @(negedge clk);
      end
    end
    check("gnt_seen", 32'(found), 1);
  endtask

  task automatic wait_rsp(output logic e, output logic [5:0] p, output logic [1:0] id,
                          output int t, output logic [11:0] rr);
    logic found;
    found = 1'b0;
    e = 1'b0; p = '0; id = '0; t = 0; rr = '0;
    ki_low = 0;
    gnt_seen = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (!ki) ki_low++;
      if (gnt != 0) gnt_seen++;
      if (rsp_valid) begin
        found = 1'b1;
        e  = rsp_err;
        p  = rsp_p;
        id = rsp_id;
        t  = cyc;
        rr = {a_rail1, a_rail0, b_rail1, b_rail0};
      end
    end
    check("rsp_seen", 32'(found), 1);
  endtask

  task automatic serve_one(input int r, input logic [2:0] a, input logic [2:0] b,
                           output logic e, output logic [5:0] p, output logic [1:0] id,
                           output int lat);
    logic [3:0] g;
    int tg, tr;
    req_a[3*r +: 3] = a;
    req_b[3*r +: 3] = b;
    req = 4'(1 << r);
    wait_gnt(g, tg);
    check("gnt_onehot", 32'(g), 1 << r);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rails_d = {a_rail1, a_rail0, b_rail1, b_rail0};
    wait_rsp(e, p, id, tr, rails_r);
    lat = tr - tg;
  endtask

  task automatic count_mult_rst(output int n);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (mult_rst) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       e;
    logic [5:0] p;
    logic [1:0] id;
    logic [3:0] g;
    logic [11:0] rr;
    int lat, tg, tr, nrst;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int exp_p  [5] = '{12, 30, 14, 42, 12};
    logic [2:0] ca [3] = '{3'd0, 3'd7, 3'd7};
    logic [2:0] cb [3] = '{3'd0, 3'd7, 3'd1};
    int cp [3] = '{0, 49, 7};

    do_reset();

    // single request, 5 x 7
    serve_one(0, 3'd5, 3'd7, e, p, id, lat);
    check("t1_rails_data", 32'(rails_d), 'hAB8);
    check("t1_p", 32'(p), 35);
    check("t1_id", 32'(id), 0);
    check("t1_err", 32'(e), 0);
    check("t1_latency", lat, 9);
    check("t1_ki_low", ki_low, 3);
    check("t1_rails_null", 32'(rails_r), 0);

    // all requesters continuously, pointer from 0
    do_reset();
    req_a = {3'd7, 3'd2, 3'd6, 3'd3};
    req_b = {3'd6, 3'd7, 3'd5, 3'd4};
    req   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, tg);
      check("t2_gnt", 32'(g), 1 << exp_id[i]);
      wait_rsp(e, p, id, tr, rr);
      if (i == 4) req = '0;
      check("t2_id", 32'(id), exp_id[i]);
      check("t2_p", 32'(p), exp_p[i]);
      check("t2_err", 32'(e), 0);
      check("t2_no_overlap", gnt_seen, 0);
    end

    // corner operands
    for (int i = 0; i < 3; i++) begin
      serve_one(2, ca[i], cb[i], e, p, id, lat);
      check("t3_p", 32'(p), cp[i]);
      check("t3_id", 32'(id), 2);
      check("t3_lat_min", 32'(lat >= 9), 1);
    end

    // island never completes
    mode = 1;
    serve_one(1, 3'd3, 3'd3, e, p, id, lat);
    check("t4_err", 32'(e), 1);
    check("t4_p", 32'(p), 0);
    check("t4_latency", lat, 67);
    count_mult_rst(nrst);
    check("t4_mult_rst_cycles", nrst, 4);
    mode = 0;
    serve_one(1, 3'd2, 3'd3, e, p, id, lat);
    check("t4_recover_p", 32'(p), 6);
    check("t4_recover_err", 32'(e), 0);

    // illegal rail code on bit 3
    mode = 2;
    serve_one(3, 3'd5, 3'd5, e, p, id, lat);
    check("t5_err", 32'(e), 1);
    check("t5_p", 32'(p), 0);
    check("t5_id", 32'(id), 3);
    check("t5_latency", lat, 5);
    count_mult_rst(nrst);
    check("t5_mult_rst_cycles", nrst, 4);
    mode = 0;

    // reset while waiting for DATA completion
    mode = 1;
    req_a[2:0] = 3'd1;
    req_b[2:0] = 3'd1;
    req = 4'b0001;
    wait_gnt(g, tg);
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req = 4'hF;
    @(negedge clk);
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_rails", 32'({a_rail1, a_rail0, b_rail1, b_rail0}), 0);
    check("t6_mult_rst", 32'(mult_rst), 1);
    check("t6_gnt", 32'(gnt), 0);
    check("t6_busy", 32'(busy), 1);
    check("t6_ki", 32'(ki), 1);
    mode = 0;
    do_reset();
    serve_one(0, 3'd6, 3'd3, e, p, id, lat);
    check("t6_after_p", 32'(p), 18);
    check("t6_after_err", 32'(e), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
